keypad_letter_entry: RTL and testbench
======================================

Name: keypad_letter_entry

Overview:
- Upstream input stage for the UART transmit path of the word game.
- Scans a 4x4 matrix keypad, debounces key presses, and turns phone-style multi-tap presses into single uppercase ASCII letters.
- Each letter is emitted as a one-cycle `msg`/`ready` pair, which is exactly what the transmit integration expects on its `msg`/`ready` inputs.

Parameters:
- SCAN_CYCLES, 1000: clock cycles each row is driven before the scan moves to the next row.
- DEBOUNCE_SCANS, 3: number of consecutive full 4-row scans that must return the same key code before a press is accepted.
- TAP_TIMEOUT, 12000000: cycles of inactivity after which a pending letter is auto-committed. Only used when KEYPAD_AUTOCOMMIT_EN is defined.

Ports:
- clk  in  1  system clock
- nRst  in  1  reset; synchronous, active-low
- col  in  4  keypad column sense, active-high, asynchronous to clk
- row  out  4  one-hot active-high row drive
- msg  out  8  committed ASCII letter
- ready  out  1  one-cycle pulse; `msg` is valid in the same cycle
- pending_valid  out  1  a letter is currently being multi-tapped
- pending_char  out  8  ASCII of the letter currently being multi-tapped

Behaviour:
- Reset values (synchronous, `nRst`=0 at a clk edge):
  - `row`=4'b0001, `msg`=8'h00, `ready`=0, `pending_valid`=0, `pending_char`=8'h00.
  - All counters and synchronisers cleared.
  - FSM in IDLE.
  - Reset mid-operation discards any pending letter with no `ready` pulse.
- `col` synchronisation: 2-flop synchroniser on `col` before any use.
- Scan:
  - `row` rotates 0001→0010→0100→1000→0001, advancing every SCAN_CYCLES cycles.
  - Columns are sampled in the last cycle of each row slot.
- Key code per full scan:
  - Exactly one row/col contact → valid code {row,col}.
  - Zero contacts, or two or more contacts → "none".
- Debounce and press event:
  - A press event is a one-cycle pulse.
  - It fires when the code changes from "none" to a valid code, and that code has then been stable for DEBOUNCE_SCANS full scans.
  - A held key does not repeat.
  - A release must be "none" for DEBOUNCE_SCANS scans before a new press can be accepted.
- Layout, row-major:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- Letter groups: 2=ABC, 3=DEF, 4=GHI, 5=JKL, 6=MNO, 7=PQRS, 8=TUV, 9=WXYZ. Keys 1, 0 and A–D are ignored.
- FSM states:
  - IDLE:
    - letter key → PENDING with `pending_char` = first letter of the group, tap index 0.
    - '#' and '*' → ignored.
  - PENDING, on a press event:
    - Same letter key → tap index = (index+1) mod group size. Wraps, e.g. S→P.
    - Different letter key → `ready`=1 and `msg`=old `pending_char` in the same cycle that the new group's first letter loads; stay in PENDING.
    - '#' → `ready`=1, `msg`=`pending_char`, go to IDLE.
    - '*' → clear, go to IDLE, no `ready`.
    - Ignored keys → no effect.
  - PENDING, timeout: when KEYPAD_AUTOCOMMIT_EN is defined and the inactivity timer reaches TAP_TIMEOUT-1, commit as for '#'.
- Timing:
  - `ready` and `pending_*` update on the clock edge after the press-event cycle, i.e. 1-cycle latency from the press event.
  - `pending_valid`=1 exactly in PENDING.
  - `msg` holds its last committed value between pulses.
- Inactivity timer: resets on every accepted letter-key press; saturates and does not wrap.
- Simultaneous timeout and press event in the same cycle: the press event has priority and the timer restarts.

Optional Feature:
- Macro: KEYPAD_AUTOCOMMIT_EN.
- Defined: the inactivity timer exists, and a timeout commits the pending letter with a `ready` pulse.
- Undefined: no timer logic is synthesised; a pending letter is held until '#', '*' or a different letter key.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (IDLE, PENDING);
  - the 5-bit key-code typedef {valid, row[1:0], col[1:0]};
  - localparams for the '*'/'#' codes;
  - a 10-entry group table giving first-letter ASCII and group size, indexed by digit.
- Sub-module keypad_scanner: row rotation, column synchroniser, debounce and press-event generation. It outputs `key_code` and `press_evt` to the multi-tap FSM in the top module.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=2, TAP_TIMEOUT=200):
- Press '2' twice (release between), then '#' → `pending_char` 8'h41 then 8'h42; one `ready` with `msg`=8'h42; `pending_valid` drops.
- Press '7' five times, then '#' → sequence P,Q,R,S,P; `msg`=8'h50.
- Press '2', then '3' → `ready` with `msg`=8'h41 in the same cycle that `pending_char`=8'h44.
- Press '9', then '*' → no `ready`; `pending_valid`=0. Press '2' and '5' together → no press event.
- With KEYPAD_AUTOCOMMIT_EN: press '4', idle 200 cycles → `ready` with `msg`=8'h47. Without the macro: no `ready` after 1000 cycles.
- Press '6', then drive `nRst`=0 for 1 cycle → all outputs at reset values, no `ready`. Key held for 50 scans → exactly one press event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and tables for the keypad letter-entry block: FSM states,
// the 5-bit key code, the '*'/'#' codes and the digit-to-letter-group table.
package keypad_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;

  typedef struct packed {
    logic [7:0] first;
    logic [2:0] size;
  } grp_t;

  localparam key_code_t KEY_STAR = '{valid: 1'b1, row: 2'd3, col: 2'd0};
  localparam key_code_t KEY_HASH = '{valid: 1'b1, row: 2'd3, col: 2'd2};
  localparam logic [3:0] NO_DIGIT = 4'hF;

  // A zero group size marks a digit that carries no letters.
  localparam grp_t [0:9] GRP_TABLE = '{
    '{first: 8'h00, size: 3'd0},
    '{first: 8'h00, size: 3'd0},
    '{first: 8'h41, size: 3'd3},
    '{first: 8'h44, size: 3'd3},
    '{first: 8'h47, size: 3'd3},
    '{first: 8'h4A, size: 3'd3},
    '{first: 8'h4D, size: 3'd3},
    '{first: 8'h50, size: 3'd4},
    '{first: 8'h54, size: 3'd3},
    '{first: 8'h57, size: 3'd4}
  };

  function automatic logic [3:0] key_digit(key_code_t k);
    if (!k.valid) return NO_DIGIT;
    if (k.row != 2'd3 && k.col != 2'd3)
      return 4'({2'b00, k.row}) * 4'd3 + 4'({2'b00, k.col}) + 4'd1;
    if (k.row == 2'd3 && k.col == 2'd1) return 4'd0;
    return NO_DIGIT;
  endfunction

endpackage

// File: rtl/keypad_letter_entry_if.sv
// Letter output bundle: committed letter pulse plus the in-progress letter.
interface keypad_letter_entry_if;
  logic [7:0] msg;
  logic       ready;
  logic       pending_valid;
  logic [7:0] pending_char;

  modport master (output msg, output ready, output pending_valid, output pending_char);
  modport slave  (input  msg, input  ready, input  pending_valid, input  pending_char);
endinterface

// File: rtl/keypad_scanner.sv
// Row rotation, column synchroniser, per-scan key decode, debounce and
// one-cycle press-event generation for a 4x4 matrix keypad.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic      clk,
  input  logic      nRst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output key_code_t key_code,
  output logic      press_evt
);

  localparam int SC_W = $clog2(SCAN_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  logic [3:0]      col_p0, col_p1;
  logic [SC_W-1:0] slot_cnt;
  logic [1:0]      row_idx;
  logic [1:0]      hit_cnt;
  logic [1:0]      hit_row, hit_col;
  key_code_t       last_code, deb_code;
  logic [DB_W-1:0] stable_cnt;

  logic [2:0]      n_col, tot;
  logic [1:0]      n_sat, hit_sum, c_idx, sum_row, sum_col;
  key_code_t       scan_code;
  logic [DB_W-1:0] stable_next;

  assign row = 4'b0001 << row_idx;

  // Contact count saturates at 2: anything above one contact is "none".
  always_comb begin
    n_col = 3'(col_p1[0]) + 3'(col_p1[1]) + 3'(col_p1[2]) + 3'(col_p1[3]);
    n_sat = (n_col > 3'd1) ? 2'd2 : n_col[1:0];
    c_idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (col_p1[i]) c_idx = 2'(i);
    tot     = 3'(hit_cnt) + 3'(n_sat);
    hit_sum = (tot > 3'd1) ? 2'd2 : tot[1:0];
    sum_row = (n_sat == 2'd1) ? row_idx : hit_row;
    sum_col = (n_sat == 2'd1) ? c_idx   : hit_col;
    scan_code = '0;
    if (hit_sum == 2'd1) scan_code = '{valid: 1'b1, row: sum_row, col: sum_col};
    stable_next = DB_W'(1);
    if (scan_code == last_code)
      stable_next = (stable_cnt == DB_TARGET) ? stable_cnt : stable_cnt + DB_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      col_p0     <= '0;
      col_p1     <= '0;
      slot_cnt   <= '0;
      row_idx    <= '0;
      hit_cnt    <= '0;
      hit_row    <= '0;
      hit_col    <= '0;
      last_code  <= '0;
      deb_code   <= '0;
      stable_cnt <= '0;
      key_code   <= '0;
      press_evt  <= 1'b0;
    end else begin
      col_p0    <= col;
      col_p1    <= col_p0;
      press_evt <= 1'b0;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        if (row_idx != 2'd3) begin
          hit_cnt <= hit_sum;
          hit_row <= sum_row;
          hit_col <= sum_col;
        end else begin
          // Full scan complete: feed the debouncer and start a fresh scan.
          hit_cnt    <= '0;
          last_code  <= scan_code;
          stable_cnt <= stable_next;
          if (stable_next == DB_TARGET) begin
            deb_code <= scan_code;
            if (!deb_code.valid && scan_code.valid) begin
              press_evt <= 1'b1;
              key_code  <= scan_code;
            end
          end
        end
      end else begin
        slot_cnt <= slot_cnt + SC_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_letter_entry.sv
// Keypad multi-tap letter entry: scans/debounces the keypad and emits one
// ASCII letter per commit. Define KEYPAD_AUTOCOMMIT_EN for inactivity auto-commit.
module keypad_letter_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int TAP_TIMEOUT    = 12000000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] col,
  output logic [3:0] row,
  keypad_letter_entry_if.master tx
);

  if (TAP_TIMEOUT < 2) begin : g_cfg_check
    $error("TAP_TIMEOUT must be at least 2");
  end

  key_code_t  key_code;
  logic       press_evt;
  state_t     state;
  logic [1:0] tap_idx, tap_next;
  logic [3:0] cur_digit, evt_digit;
  grp_t       cur_grp, evt_grp;
  logic       evt_letter;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk       (clk),
    .nRst      (nRst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .press_evt (press_evt)
  );

  always_comb begin
    evt_digit  = key_digit(key_code);
    evt_grp    = (evt_digit <= 4'd9) ? GRP_TABLE[evt_digit] : '0;
    evt_letter = (evt_grp.size != 3'd0);
    cur_grp    = (cur_digit <= 4'd9) ? GRP_TABLE[cur_digit] : '0;
    tap_next   = (3'(tap_idx) + 3'd1 == cur_grp.size) ? 2'd0 : tap_idx + 2'd1;
  end

`ifdef KEYPAD_AUTOCOMMIT_EN
  localparam int TMR_W = $clog2(TAP_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TAP_TIMEOUT - 1);
  logic [TMR_W-1:0] idle_tmr;
`endif

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state            <= IDLE;
      tap_idx          <= '0;
      cur_digit        <= '0;
      tx.msg           <= '0;
      tx.ready         <= 1'b0;
      tx.pending_valid <= 1'b0;
      tx.pending_char  <= '0;
`ifdef KEYPAD_AUTOCOMMIT_EN
      idle_tmr         <= '0;
`endif
    end else begin
      tx.ready <= 1'b0;
      if (press_evt) begin
        if (evt_letter) begin
          if (state == PENDING && evt_digit == cur_digit) begin
            tap_idx         <= tap_next;
            tx.pending_char <= cur_grp.first + 8'(tap_next);
          end else begin
            // A different group commits the old letter while the new one loads.
            if (state == PENDING) begin
              tx.ready <= 1'b1;
              tx.msg   <= tx.pending_char;
            end
            state            <= PENDING;
            tx.pending_valid <= 1'b1;
            cur_digit        <= evt_digit;
            tap_idx          <= '0;
            tx.pending_char  <= evt_grp.first;
          end
`ifdef KEYPAD_AUTOCOMMIT_EN
          idle_tmr <= '0;
`endif
        end else if (state == PENDING && key_code == KEY_HASH) begin
          tx.ready         <= 1'b1;
          tx.msg           <= tx.pending_char;
          state            <= IDLE;
          tx.pending_valid <= 1'b0;
          tx.pending_char  <= '0;
        end else if (state == PENDING && key_code == KEY_STAR) begin
          state            <= IDLE;
          tx.pending_valid <= 1'b0;
          tx.pending_char  <= '0;
        end
      end
`ifdef KEYPAD_AUTOCOMMIT_EN
      else if (state == PENDING) begin
        if (idle_tmr == TMR_LAST) begin
          tx.ready         <= 1'b1;
          tx.msg           <= tx.pending_char;
          state            <= IDLE;
          tx.pending_valid <= 1'b0;
          tx.pending_char  <= '0;
        end else begin
          idle_tmr <= idle_tmr + TMR_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_keypad_letter_entry.sv
// Directed bench for keypad_letter_entry: table of single-key taps with
// expected letter state, plus hand-written reset, hold, chord and timeout cases.
`timescale 1ns/1ps
module tb_keypad_letter_entry;

  localparam int SC   = 4;
  localparam int DB   = 2;
  localparam int TO   = 200;
  localparam int SCAN = 4 * SC;
  localparam int HOLD = 4 * SCAN;
  localparam int REL  = 4 * SCAN;
  localparam int NV   = 16;

  logic        clk  = 1'b0;
  logic        nRst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys = '0;

  keypad_letter_entry_if tx_if();

  keypad_letter_entry #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_SCANS (DB),
    .TAP_TIMEOUT    (TO)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .col  (col),
    .row  (row),
    .tx   (tx_if)
  );

  always #5 clk = ~clk;

  // Keypad contact model: a pressed key connects its row drive to its column.
  always_comb begin
    col = '0;
    for (int r = 0; r < 4; r++)
      if (row[r]) col = col | keys[r*4 +: 4];
  end

  int         rdy_cnt  = 0;
  int         evt_cnt  = 0;
  logic [7:0] rdy_msg  = '0;
  logic [7:0] rdy_pend = '0;

  always @(negedge clk) begin
    if (tx_if.ready === 1'b1) begin
      rdy_cnt  = rdy_cnt + 1;
      rdy_msg  = tx_if.msg;
      rdy_pend = tx_if.pending_char;
    end
    if (dut.u_scan.press_evt === 1'b1) evt_cnt = evt_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tap(input logic [15:0] k);
    keys = k;
    repeat (HOLD) @(posedge clk);
    keys = '0;
    repeat (REL) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         key;
    logic       pv;
    logic [7:0] pc;
    int         rdy;
    logic [7:0] msg;
  } vec_t;

  vec_t vecs [NV];
  int   r0;
  int   e0;

  initial begin
    // key index = row*4 + col: '2'=1 '3'=2 '7'=8 '9'=10 '1'=0 '*'=12 '#'=14
    vecs[0]  = '{1,  1'b1, 8'h41, 0, 8'h00};
    vecs[1]  = '{1,  1'b1, 8'h42, 0, 8'h00};
    vecs[2]  = '{14, 1'b0, 8'h00, 1, 8'h42};
    vecs[3]  = '{8,  1'b1, 8'h50, 0, 8'h00};
    vecs[4]  = '{8,  1'b1, 8'h51, 0, 8'h00};
    vecs[5]  = '{8,  1'b1, 8'h52, 0, 8'h00};
    vecs[6]  = '{8,  1'b1, 8'h53, 0, 8'h00};
    vecs[7]  = '{8,  1'b1, 8'h50, 0, 8'h00};
    vecs[8]  = '{14, 1'b0, 8'h00, 1, 8'h50};
    vecs[9]  = '{1,  1'b1, 8'h41, 0, 8'h00};
    vecs[10] = '{2,  1'b1, 8'h44, 1, 8'h41};
    vecs[11] = '{14, 1'b0, 8'h00, 1, 8'h44};
    vecs[12] = '{10, 1'b1, 8'h57, 0, 8'h00};
    vecs[13] = '{12, 1'b0, 8'h00, 0, 8'h00};
    vecs[14] = '{0,  1'b0, 8'h00, 0, 8'h00};
    vecs[15] = '{14, 1'b0, 8'h00, 0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", 32'(row), 32'h1);
    chk("rst_msg", 32'(tx_if.msg), 32'h0);
    chk("rst_ready", 32'(tx_if.ready), 32'h0);
    chk("rst_pv", 32'(tx_if.pending_valid), 32'h0);
    chk("rst_pc", 32'(tx_if.pending_char), 32'h0);
    @(negedge clk);
    nRst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      r0 = rdy_cnt;
      tap(16'd1 << vecs[i].key);
      chk($sformatf("v%0d_pv", i), 32'(tx_if.pending_valid), 32'(vecs[i].pv));
      if (vecs[i].pv) chk($sformatf("v%0d_pc", i), 32'(tx_if.pending_char), 32'(vecs[i].pc));
      chk($sformatf("v%0d_rdy", i), 32'(rdy_cnt - r0), 32'(vecs[i].rdy));
      if (vecs[i].rdy > 0) begin
        chk($sformatf("v%0d_msg", i), 32'(rdy_msg), 32'(vecs[i].msg));
        chk($sformatf("v%0d_msg_hold", i), 32'(tx_if.msg), 32'(vecs[i].msg));
        if (vecs[i].pv)
          chk($sformatf("v%0d_same_cycle", i), 32'(rdy_pend), 32'(vecs[i].pc));
      end
    end

    // '2' and '5' pressed together: two contacts in one scan, no press event.
    e0 = evt_cnt;
    r0 = rdy_cnt;
    tap(16'h0022);
    chk("chord_evt", 32'(evt_cnt - e0), 32'h0);
    chk("chord_pv", 32'(tx_if.pending_valid), 32'h0);
    chk("chord_rdy", 32'(rdy_cnt - r0), 32'h0);

    // '4' then inactivity.
    r0 = rdy_cnt;
    tap(16'h0010);
    chk("to_pc", 32'(tx_if.pending_char), 32'h47);
`ifdef KEYPAD_AUTOCOMMIT_EN
    repeat (TO) @(posedge clk);
    #1;
    chk("to_rdy", 32'(rdy_cnt - r0), 32'h1);
    chk("to_msg", 32'(rdy_msg), 32'h47);
    chk("to_pv", 32'(tx_if.pending_valid), 32'h0);
`else
    repeat (1000) @(posedge clk);
    #1;
    chk("hold_rdy", 32'(rdy_cnt - r0), 32'h0);
    chk("hold_pv", 32'(tx_if.pending_valid), 32'h1);
    chk("hold_pc", 32'(tx_if.pending_char), 32'h47);
    tap(16'h1000);
    chk("hold_clear_pv", 32'(tx_if.pending_valid), 32'h0);
`endif

    // '6' pending, then a one-cycle reset discards it silently.
    tap(16'h0040);
    chk("mr_pc", 32'(tx_if.pending_char), 32'h4D);
    r0 = rdy_cnt;
    @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    chk("mr_row", 32'(row), 32'h1);
    chk("mr_msg", 32'(tx_if.msg), 32'h0);
    chk("mr_ready", 32'(tx_if.ready), 32'h0);
    chk("mr_pv", 32'(tx_if.pending_valid), 32'h0);
    chk("mr_pc", 32'(tx_if.pending_char), 32'h0);
    repeat (SCAN) @(posedge clk);
    #1;
    chk("mr_no_rdy", 32'(rdy_cnt - r0), 32'h0);

    // '2' held for 50 scans: exactly one press event, no repeat taps.
    e0 = evt_cnt;
    keys = 16'h0002;
    repeat (50 * SCAN) @(posedge clk);
    #1;
    chk("held_pc", 32'(tx_if.pending_char), 32'h41);
    keys = '0;
    repeat (REL) @(posedge clk);
    #1;
    chk("held_evt", 32'(evt_cnt - e0), 32'h1);
    tap(16'h1000);
    chk("held_clear_pv", 32'(tx_if.pending_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
